pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program counter for the microprocessor datapath: holds an ADDR_W-bit fetch address and supports increment, atomic multi-chunk absolute load from the BUS_W-bit data bus, signed relative jump, and call/return through an internal return-address stack. It sits between the control sequencer, which drives the command strobes, and the instruction-fetch address path, which consumes pc_out.

## Interface
- ADDR_W, 16, PC width; must be an integer multiple of BUS_W
- BUS_W, 8, data-bus width; NCHUNK = ADDR_W/BUS_W chunks per absolute load
- STACK_DEPTH, 4, return-address stack entries (≥1)
- RESET_ADDR, 0, value of pc_out after reset
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  synchronous, active-low reset
- pc_in  in  BUS_W  load chunk (absolute load) or signed offset (jrel)
- ld  in  1  absolute-load strobe; one chunk per cycle with ld high
- call  in  1  qualifies a load that starts in IDLE as a call
- ret  in  1  pop return address into PC
- jrel  in  1  PC <= PC + sign_extend(pc_in)
- inc  in  1  PC <= PC + 1
- pc_out  out  ADDR_W  current PC, registered
- busy  out  1  multi-chunk load in progress
- stk_full  out  1  stack holds STACK_DEPTH entries
- stk_empty  out  1  stack holds 0 entries
- stk_err  out  1  one-cycle pulse on overflow or underflow

## Operation
- Reset (rst_n=0 at edge): pc_out=RESET_ADDR, state IDLE, chunk count 0, call flag 0, stack pointer 0, busy=0, stk_full=0, stk_empty=1, stk_err=0. Reset during a load discards all captured chunks.
- States: IDLE and LOAD.
- IDLE command priority: ld > ret > jrel > inc. Only the highest-priority command acts. With none asserted, PC holds.
- ld in IDLE: the low chunk (bits BUS_W-1:0) goes into a shadow register. The call flag latches the value of call. The chunk counter becomes 1. Next state is LOAD.
  - If NCHUNK=1, the load commits immediately instead and the state stays IDLE.
- LOAD: each cycle with ld=1 captures the next-higher chunk.
  - A cycle with ld=0 stalls; captured chunks are kept.
  - inc, jrel, ret and call are ignored in LOAD.
  - On the NCHUNK-th chunk: PC <= full shadow value, applied atomically. pc_out never shows a partial address. Next state is IDLE.
- Commit with call flag set: push (PC_at_load_start + 1) mod 2^ADDR_W. If the stack is full, drop the push, pulse stk_err, and perform the jump anyway.
- ret in IDLE: PC <= top of stack and pop. If the stack is empty, PC holds and stk_err pulses.
- jrel: offset is pc_in sign-extended to ADDR_W. Sum is taken mod 2^ADDR_W.
- inc: (2^ADDR_W − 1) + 1 wraps to 0.
- Stack: LIFO, pointer range 0..STACK_DEPTH. stk_full and stk_empty are decoded from the pointer and registered along with it.

## Timing
- All outputs are registered. A command sampled at edge k is visible on pc_out after edge k.
- inc, jrel and ret have 1-cycle latency and can be issued back-to-back every cycle.
- Absolute load: the new PC appears after the edge that samples the NCHUNK-th ld-high cycle.
  - With no stalls, the minimum is NCHUNK cycles, e.g. 2 cycles for 16/8.
- busy rises after the first-chunk edge and falls after the commit edge. busy stays 0 when NCHUNK=1.
- stk_err is high for exactly the cycle following the faulting edge.
- Stack flags update on the same edge as the push or pop.
- Simultaneous strobes follow the priority rule above. call without ld is ignored.

## Test plan
- Reset/inc: release rst_n with RESET_ADDR=0, then 3 inc cycles -> pc_out 0,1,2,3. From PC=16'hFFFF, one inc -> 16'h0000.
- Load with stall: ld with pc_in=8'h34, then ld=0 for 2 cycles, then ld with pc_in=8'h12 -> pc_out holds the old value throughout, busy=1 during the stall, then pc_out=16'h1234 and busy=0.
- Relative jump: from PC=16'h0100, jrel with 8'hFE -> 16'h00FE. From 16'hFFFF, jrel with 8'h02 -> 16'h0001.
- Call/return: from PC=16'h0010, load 16'hABCD with call=1 on the first chunk -> pc_out=16'hABCD, stk_empty=0. Then ret -> pc_out=16'h0011, stk_empty=1.
- Stack limits (STACK_DEPTH=4): 5 calls -> stk_full=1 after the 4th call, stk_err pulses once on the 5th, and the 5th jump still takes effect. Then 5 rets -> the 5th ret leaves PC unchanged and pulses stk_err.
- Priority and reset mid-load: ld, ret and inc all high in IDLE -> a load starts and the stack is unchanged. Asserting rst_n=0 while busy -> pc_out=RESET_ADDR and busy=0, with no partial commit.

Source files
------------

// File: rtl/pc_unit.sv
// Program counter with increment, relative jump, multi-chunk absolute load
// and call/return through a small internal return-address stack.
module pc_unit #(
  parameter int                ADDR_W      = 16,
  parameter int                BUS_W       = 8,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BUS_W-1:0]  pc_in,
  input  logic              ld,
  input  logic              call,
  input  logic              ret,
  input  logic              jrel,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc_out,
  output logic              busy,
  output logic              stk_full,
  output logic              stk_empty,
  output logic              stk_err
);

  localparam int NCHUNK = ADDR_W / BUS_W;
  localparam int CNT_W  = $clog2(NCHUNK) + 1;
  localparam int SP_W   = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);
  localparam logic [SP_W-1:0]  SP_MAX     = SP_W'(STACK_DEPTH);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   pc_n;
  logic [ADDR_W-1:0]   shadow, shadow_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic                call_q, call_n;
  logic [SP_W-1:0]     sp, sp_n;
  logic                err_n;
  logic                push;
  logic                commit, commit_call;
  logic [ADDR_W-1:0]   commit_val;
  logic [ADDR_W-1:0]   offset;
  logic [ADDR_W-1:0]   ret_addr;
  logic [IDX_W-1:0]    top_idx, push_idx;
  logic [ADDR_W-1:0]   stack [STACK_DEPTH];

  assign offset   = ADDR_W'($signed(pc_in));
  assign ret_addr = pc_out + ADDR_W'(1);
  assign top_idx  = IDX_W'(sp - SP_W'(1));
  assign push_idx = IDX_W'(sp);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc_out    <= RESET_ADDR;
      shadow    <= '0;
      cnt       <= '0;
      call_q    <= 1'b0;
      sp        <= '0;
      stk_full  <= 1'b0;
      stk_empty <= 1'b1;
      stk_err   <= 1'b0;
    end else begin
      state     <= state_n;
      pc_out    <= pc_n;
      shadow    <= shadow_n;
      cnt       <= cnt_n;
      call_q    <= call_n;
      sp        <= sp_n;
      stk_full  <= (sp_n == SP_MAX);
      stk_empty <= (sp_n == '0);
      stk_err   <= err_n;
    end
  end

  // Stack storage needs no reset; only the pointer defines what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && push) stack[push_idx] <= ret_addr;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (ld && (NCHUNK > 1)) state_n = LOAD;
      LOAD:    if (ld && (cnt == LAST_CHUNK)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // PC stays untouched throughout LOAD, so pc_out + 1 at commit is the
  // return address of the instruction that started the call.
  always_comb begin
    pc_n        = pc_out;
    shadow_n    = shadow;
    cnt_n       = cnt;
    call_n      = call_q;
    sp_n        = sp;
    err_n       = 1'b0;
    push        = 1'b0;
    commit      = 1'b0;
    commit_call = 1'b0;
    commit_val  = shadow;
    unique case (state)
      IDLE: begin
        if (ld) begin
          if (NCHUNK == 1) begin
            commit      = 1'b1;
            commit_call = call;
            commit_val  = ADDR_W'(pc_in);
          end else begin
            shadow_n = ADDR_W'(pc_in);
            cnt_n    = CNT_W'(1);
            call_n   = call;
          end
        end else if (ret) begin
          if (sp == '0) begin
            err_n = 1'b1;
          end else begin
            pc_n = stack[top_idx];
            sp_n = sp - SP_W'(1);
          end
        end else if (jrel) begin
          pc_n = pc_out + offset;
        end else if (inc) begin
          pc_n = pc_out + ADDR_W'(1);
        end
      end
      LOAD: begin
        if (ld) begin
          for (int i = 0; i < NCHUNK; i++) begin
            if (cnt == CNT_W'(i)) shadow_n[i*BUS_W +: BUS_W] = pc_in;
          end
          if (cnt == LAST_CHUNK) begin
            commit      = 1'b1;
            commit_call = call_q;
            commit_val  = shadow_n;
            cnt_n       = '0;
            call_n      = 1'b0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      default: ;
    endcase
    // A call into a full stack still jumps; only the push is dropped.
    if (commit) begin
      pc_n = commit_val;
      if (commit_call) begin
        if (sp == SP_MAX) begin
          err_n = 1'b1;
        end else begin
          push = 1'b1;
          sp_n = sp + SP_W'(1);
        end
      end
    end
  end

  always_comb begin
    busy = (state == LOAD);
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: each step queues its expected outputs and the
// queue is drained one entry per clock just after the active edge.
module tb_pc_unit;

  logic        clk;
  logic        rst_n;
  logic [7:0]  pc_in;
  logic        ld, call, ret, jrel, inc;
  logic [15:0] pc_out;
  logic        busy, stk_full, stk_empty, stk_err;

  typedef struct {
    logic [15:0] pc;
    logic        busy;
    logic        full;
    logic        empty;
    logic        err;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  pc_unit #(
    .ADDR_W(16), .BUS_W(8), .STACK_DEPTH(4), .RESET_ADDR(16'h0000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .ld(ld), .call(call),
    .ret(ret), .jrel(jrel), .inc(inc), .pc_out(pc_out), .busy(busy),
    .stk_full(stk_full), .stk_empty(stk_empty), .stk_err(stk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output();
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard: got empty queue, expected an entry");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      assert (pc_out === e.pc) else begin
        errors++;
        $error("[TB] FAIL %s.pc: got %h expected %h", e.tag, pc_out, e.pc);
      end
      checks++;
      assert (busy === e.busy) else begin
        errors++;
        $error("[TB] FAIL %s.busy: got %b expected %b", e.tag, busy, e.busy);
      end
      checks++;
      assert (stk_full === e.full) else begin
        errors++;
        $error("[TB] FAIL %s.stk_full: got %b expected %b", e.tag, stk_full, e.full);
      end
      checks++;
      assert (stk_empty === e.empty) else begin
        errors++;
        $error("[TB] FAIL %s.stk_empty: got %b expected %b", e.tag, stk_empty, e.empty);
      end
      checks++;
      assert (stk_err === e.err) else begin
        errors++;
        $error("[TB] FAIL %s.stk_err: got %b expected %b", e.tag, stk_err, e.err);
      end
    end
  endtask

  task automatic step(input logic r, input logic l, input logic c,
                      input logic rt, input logic j, input logic i,
                      input logic [7:0] d, input logic [15:0] e_pc,
                      input logic e_busy, input logic e_full,
                      input logic e_empty, input logic e_err, input string tag);
    exp_t e;
    rst_n = r; ld = l; call = c; ret = rt; jrel = j; inc = i; pc_in = d;
    e.pc = e_pc; e.busy = e_busy; e.full = e_full;
    e.empty = e_empty; e.err = e_err; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_output();
  endtask

  initial begin
    rst_n = 1'b0; ld = 1'b0; call = 1'b0; ret = 1'b0; jrel = 1'b0; inc = 1'b0;
    pc_in = 8'h00;
    @(negedge clk);
    //   rst ld cl rt jr in din    pc        bz fu em er tag
    step(0, 0, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 0, 1, 0, "reset");
    step(1, 0, 0, 0, 0, 1, 8'h00, 16'h0001, 0, 0, 1, 0, "inc1");
    step(1, 0, 0, 0, 0, 1, 8'h00, 16'h0002, 0, 0, 1, 0, "inc2");
    step(1, 0, 0, 0, 0, 1, 8'h00, 16'h0003, 0, 0, 1, 0, "inc3");
    step(1, 1, 0, 0, 0, 0, 8'hFF, 16'h0003, 1, 0, 1, 0, "ldffff_c0");
    step(1, 1, 0, 0, 0, 0, 8'hFF, 16'hFFFF, 0, 0, 1, 0, "ldffff_c1");
    step(1, 0, 0, 0, 0, 1, 8'h00, 16'h0000, 0, 0, 1, 0, "inc_wrap");
    // Load with a two-cycle stall; inc during LOAD must be ignored
    step(1, 1, 0, 0, 0, 0, 8'h34, 16'h0000, 1, 0, 1, 0, "stall_c0");
    step(1, 0, 0, 0, 0, 1, 8'h00, 16'h0000, 1, 0, 1, 0, "stall1");
    step(1, 0, 0, 0, 0, 0, 8'h00, 16'h0000, 1, 0, 1, 0, "stall2");
    step(1, 1, 0, 0, 0, 0, 8'h12, 16'h1234, 0, 0, 1, 0, "ld_1234");
    // Relative jumps
    step(1, 1, 0, 0, 0, 0, 8'h00, 16'h1234, 1, 0, 1, 0, "ld0100_c0");
    step(1, 1, 0, 0, 0, 0, 8'h01, 16'h0100, 0, 0, 1, 0, "ld0100_c1");
    step(1, 0, 0, 0, 1, 0, 8'hFE, 16'h00FE, 0, 0, 1, 0, "jrel_neg");
    step(1, 1, 0, 0, 0, 0, 8'hFF, 16'h00FE, 1, 0, 1, 0, "ldffff2_c0");
    step(1, 1, 0, 0, 0, 0, 8'hFF, 16'hFFFF, 0, 0, 1, 0, "ldffff2_c1");
    step(1, 0, 0, 0, 1, 0, 8'h02, 16'h0001, 0, 0, 1, 0, "jrel_wrap");
    // Call and return
    step(1, 1, 0, 0, 0, 0, 8'h10, 16'h0001, 1, 0, 1, 0, "ld0010_c0");
    step(1, 1, 0, 0, 0, 0, 8'h00, 16'h0010, 0, 0, 1, 0, "ld0010_c1");
    step(1, 1, 1, 0, 0, 0, 8'hCD, 16'h0010, 1, 0, 1, 0, "call_c0");
    step(1, 1, 0, 0, 0, 0, 8'hAB, 16'hABCD, 0, 0, 0, 0, "call_abcd");
    step(1, 0, 0, 1, 0, 0, 8'h00, 16'h0011, 0, 0, 1, 0, "ret_0011");
    // Fill the stack and overflow it
    step(1, 1, 1, 0, 0, 0, 8'h00, 16'h0011, 1, 0, 1, 0, "call1_c0");
    step(1, 1, 0, 0, 0, 0, 8'h10, 16'h1000, 0, 0, 0, 0, "call1");
    step(1, 1, 1, 0, 0, 0, 8'h00, 16'h1000, 1, 0, 0, 0, "call2_c0");
    step(1, 1, 0, 0, 0, 0, 8'h20, 16'h2000, 0, 0, 0, 0, "call2");
    step(1, 1, 1, 0, 0, 0, 8'h00, 16'h2000, 1, 0, 0, 0, "call3_c0");
    step(1, 1, 0, 0, 0, 0, 8'h30, 16'h3000, 0, 0, 0, 0, "call3");
    step(1, 1, 1, 0, 0, 0, 8'h00, 16'h3000, 1, 0, 0, 0, "call4_c0");
    step(1, 1, 0, 0, 0, 0, 8'h40, 16'h4000, 0, 1, 0, 0, "call4_full");
    step(1, 1, 1, 0, 0, 0, 8'h00, 16'h4000, 1, 1, 0, 0, "call5_c0");
    step(1, 1, 0, 0, 0, 0, 8'h50, 16'h5000, 0, 1, 0, 1, "call5_ovf");
    // Unwind and underflow
    step(1, 0, 0, 1, 0, 0, 8'h00, 16'h3001, 0, 0, 0, 0, "ret1");
    step(1, 0, 0, 1, 0, 0, 8'h00, 16'h2001, 0, 0, 0, 0, "ret2");
    step(1, 0, 0, 1, 0, 0, 8'h00, 16'h1001, 0, 0, 0, 0, "ret3");
    step(1, 0, 0, 1, 0, 0, 8'h00, 16'h0012, 0, 0, 1, 0, "ret4");
    step(1, 0, 0, 1, 0, 0, 8'h00, 16'h0012, 0, 0, 1, 1, "ret5_udf");
    step(1, 0, 0, 0, 0, 0, 8'h00, 16'h0012, 0, 0, 1, 0, "err_clear");
    // Priority with a non-empty stack, then reset while busy
    step(1, 1, 1, 0, 0, 0, 8'h00, 16'h0012, 1, 0, 1, 0, "call6_c0");
    step(1, 1, 0, 0, 0, 0, 8'h60, 16'h6000, 0, 0, 0, 0, "call6");
    step(1, 1, 0, 1, 0, 1, 8'h77, 16'h6000, 1, 0, 0, 0, "prio");
    step(0, 1, 0, 0, 0, 0, 8'h88, 16'h0000, 0, 0, 1, 0, "rst_mid");
    step(1, 0, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 0, 1, 0, "after_rst");
    step(1, 1, 0, 0, 0, 0, 8'h55, 16'h0000, 1, 0, 1, 0, "fresh_c0");
    step(1, 1, 0, 0, 0, 0, 8'h66, 16'h6655, 0, 0, 1, 0, "fresh_c1");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
